pc_fetch_gen: RTL and testbench
===============================

// Module: pc_fetch_gen
// PURPOSE
//   Registered, parametrised program-counter generator; successor to the combinational PC mux.
//   Owns the PC register, boot sequencing and redirect priority (trap > trap-return > branch > sequential).
//   Drives the instruction-fetch request with a valid/ready handshake.
//   Buffers a redirect that arrives while a fetch is stalled. Sits between decode/CSR control and the instruction memory port.
// PARAMETERS
//   XLEN         32            PC / address width
//   RESET_VECTOR 32'h0000_0000 first fetch address after reset
//   IALIGN       32            instruction alignment in bits, 16 or 32; sets the misalignment check
//   PC_STEP      4             sequential increment in bytes
// PORTS
//   clk_in            in   1      clock
//   rst_n_in          in   1      reset, asynchronous, active-low
//   stall_in          in   1      pipeline hold; blocks new requests and sequential advance
//   trap_taken_in     in   1      redirect to trap_address_in
//   trap_address_in   in   XLEN   trap handler address
//   trap_return_in    in   1      redirect to epc_in (mret)
//   epc_in            in   XLEN   return address
//   branch_taken_in   in   1      redirect to {iaddr_in,1'b0}
//   iaddr_in          in   XLEN-1 branch/jump target, bit 0 implied zero
//   i_ready_in        in   1      imem accepts current request
//   i_req_out         out  1      fetch request valid
//   i_addr_out        out  XLEN   fetch address; equals pc_out
//   pc_out            out  XLEN   registered PC of the outstanding fetch
//   pc_plus_step_out  out  XLEN   pc_out + PC_STEP (link value), combinational
//   misaligned_instr_out out 1    one-cycle pulse: branch target rejected as misaligned
//   misaligned_addr_out  out XLEN offending target, held until next pulse
// BEHAVIOUR
//   Reset (rst_n_in=0, async):
//     state=BOOT, pc_out=RESET_VECTOR, i_req_out=0, pending=0
//     misaligned_instr_out=0, misaligned_addr_out=0
//   FSM states:
//     BOOT -> FETCH on first clk edge with rst_n_in=1
//     FETCH: i_req_out=1 unless stall_in
//     FETCH -> WAIT when i_req_out & !i_ready_in
//     WAIT: i_req_out=1, i_addr_out held stable; no other i_addr_out change allowed
//     WAIT -> FETCH on i_ready_in
//   Accept = i_req_out & i_ready_in. On accept, next pc is chosen in this order:
//     1. pending redirect
//     2. same-cycle redirect
//     3. pc_out + PC_STEP
//   Redirect in FETCH with no accept (stall, or idle before request): pc_out loads the target next cycle.
//   Redirect while in WAIT: captured in pending_q/pending_addr_q, applied on accept.
//     A later redirect overwrites pending only if equal or higher priority.
//   Simultaneous redirects resolve by priority trap > trap_return > branch; lower one dropped.
//   Misaligned check, branch only: IALIGN=32 -> target[1]!=0; IALIGN=16 -> never misaligned.
//     On a misaligned branch: no redirect, misaligned_instr_out=1 for 1 cycle, misaligned_addr_out=target.
//     Trap and epc targets have their low bits (below IALIGN) forced to zero; never flagged.
//   stall_in=1: no sequential advance; redirects still captured. stall_in does not drop an in-flight WAIT request.
//   Arithmetic: PC increment is modulo 2^XLEN (wraps all-ones+step to step-1).
//   Latency: redirect to i_addr_out is 1 cycle when not in WAIT.
//   Reset asserted mid-WAIT: request dropped immediately; pending cleared.
// STRUCTURE
//   Shared package pc_pkg: state enum (BOOT, FETCH, WAIT), redirect-priority encoding, PC_STEP default.
//   Sub-module pc_redirect_arb (combinational): priority select, target formation, misalignment flag.
//   Top holds FSM, PC register, pending buffer.
// TESTING
//   Boot: release rst_n_in, i_ready_in=1 -> i_addr_out 0x0, 0x4, 0x8 on consecutive cycles.
//   Branch: branch_taken_in=1, iaddr_in=0x40 in FETCH -> next i_addr_out=0x80, then 0x84.
//   Stall redirect: i_ready_in=0 at 0x10, trap to 0x200 -> addr holds 0x10; after ready, 0x200.
//   Misaligned: iaddr_in=0x21 (target 0x42), IALIGN=32 -> pulse, misaligned_addr_out=0x42, PC continues sequentially.
//   Priority: trap(0x300)+return(0x500)+branch same cycle -> 0x300.
//   Wrap/reset: pc 0xFFFF_FFFC accepted -> 0x0; assert rst_n_in in WAIT -> i_req_out=0 asynchronously.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the fetch PC generator: FSM states, redirect priority
// encoding and default sizing.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } fetch_state_t;

  // Numeric order is the priority order, so a plain >= compares priority.
  typedef enum logic [1:0] {
    PRIO_NONE   = 2'd0,
    PRIO_BRANCH = 2'd1,
    PRIO_RET    = 2'd2,
    PRIO_TRAP   = 2'd3
  } redir_prio_t;

  localparam int XLEN_DEFAULT    = 32;
  localparam int PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: picks trap > trap-return > branch, forms the
// aligned target and rejects misaligned branch targets.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int IALIGN = 32
) (
  input  logic              trap_taken,
  input  logic [XLEN-1:0]   trap_address,
  input  logic              trap_return,
  input  logic [XLEN-1:0]   epc,
  input  logic              branch_taken,
  input  logic [XLEN-2:0]   iaddr,
  output logic              redir_valid,
  output redir_prio_t       redir_prio,
  output logic [XLEN-1:0]   redir_target,
  output logic              misaligned,
  output logic [XLEN-1:0]   branch_target
);

  // Clears the address bits below the instruction alignment.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'((IALIGN / 8) - 1));

  always_comb begin
    redir_valid   = 1'b0;
    redir_prio    = PRIO_NONE;
    redir_target  = '0;
    misaligned    = 1'b0;
    branch_target = {iaddr, 1'b0};
    if (trap_taken) begin
      redir_valid  = 1'b1;
      redir_prio   = PRIO_TRAP;
      redir_target = trap_address & ALIGN_MASK;
    end else if (trap_return) begin
      redir_valid  = 1'b1;
      redir_prio   = PRIO_RET;
      redir_target = epc & ALIGN_MASK;
    end else if (branch_taken) begin
      if (IALIGN == 32 && branch_target[1]) begin
        misaligned = 1'b1;
      end else begin
        redir_valid  = 1'b1;
        redir_prio   = PRIO_BRANCH;
        redir_target = branch_target;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// Registered program-counter generator: boot sequencing, fetch handshake,
// redirect buffering while a request is stalled by the instruction memory.
module pc_fetch_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 32,
  parameter int              PC_STEP      = PC_STEP_DEFAULT
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            stall_in,
  input  logic            trap_taken_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic            trap_return_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-2:0] iaddr_in,
  input  logic            i_ready_in,
  output logic            i_req_out,
  output logic [XLEN-1:0] i_addr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_step_out,
  output logic            misaligned_instr_out,
  output logic [XLEN-1:0] misaligned_addr_out
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pending_q;
  redir_prio_t     pending_prio_q;
  logic [XLEN-1:0] pending_addr_q;
  logic            mis_q;
  logic [XLEN-1:0] mis_addr_q;

  logic            redir_valid;
  redir_prio_t     redir_prio;
  logic [XLEN-1:0] redir_target;
  logic            misaligned;
  logic [XLEN-1:0] branch_target;
  logic            accept;

  pc_redirect_arb #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_arb (
    .trap_taken    (trap_taken_in),
    .trap_address  (trap_address_in),
    .trap_return   (trap_return_in),
    .epc           (epc_in),
    .branch_taken  (branch_taken_in),
    .iaddr         (iaddr_in),
    .redir_valid   (redir_valid),
    .redir_prio    (redir_prio),
    .redir_target  (redir_target),
    .misaligned    (misaligned),
    .branch_target (branch_target)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= BOOT;
    else           state_q <= state_d;
  end

  // The WAIT request stays up even under stall so the address cannot change.
  always_comb begin
    state_d   = state_q;
    i_req_out = 1'b0;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        i_req_out = !stall_in;
        if (!stall_in && !i_ready_in) state_d = WAIT;
      end
      WAIT: begin
        i_req_out = 1'b1;
        if (i_ready_in) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  assign accept           = i_req_out & i_ready_in;
  assign pc_plus_step_out = pc_q + XLEN'(PC_STEP);
  assign pc_out           = pc_q;
  assign i_addr_out       = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (accept) begin
      if (pending_q)        pc_d = pending_addr_q;
      else if (redir_valid) pc_d = redir_target;
      else                  pc_d = pc_plus_step_out;
    end else if (state_q != WAIT && redir_valid) begin
      pc_d = redir_target;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q           <= RESET_VECTOR;
      pending_q      <= 1'b0;
      pending_prio_q <= PRIO_NONE;
      pending_addr_q <= '0;
      mis_q          <= 1'b0;
      mis_addr_q     <= '0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= misaligned;
      if (misaligned) mis_addr_q <= branch_target;
      if (accept) begin
        pending_q      <= 1'b0;
        pending_prio_q <= PRIO_NONE;
      end else if (state_q == WAIT && redir_valid &&
                   (!pending_q || redir_prio >= pending_prio_q)) begin
        pending_q      <= 1'b1;
        pending_prio_q <= redir_prio;
        pending_addr_q <= redir_target;
      end
    end
  end

  assign misaligned_instr_out = mis_q;
  assign misaligned_addr_out  = mis_addr_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: accepted fetch addresses are checked
// against a queue of expected addresses, plus direct checks on side outputs.
module tb_pc_fetch_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        trap_taken;
  logic [31:0] trap_address;
  logic        trap_return;
  logic [31:0] epc;
  logic        branch_taken;
  logic [30:0] iaddr;
  logic        i_ready;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic        mis_instr;
  logic [31:0] mis_addr;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pc_fetch_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .IALIGN       (32),
    .PC_STEP      (4)
  ) dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .stall_in             (stall),
    .trap_taken_in        (trap_taken),
    .trap_address_in      (trap_address),
    .trap_return_in       (trap_return),
    .epc_in               (epc),
    .branch_taken_in      (branch_taken),
    .iaddr_in             (iaddr),
    .i_ready_in           (i_ready),
    .i_req_out            (i_req),
    .i_addr_out           (i_addr),
    .pc_out               (pc),
    .pc_plus_step_out     (pc_plus_step),
    .misaligned_instr_out (mis_instr),
    .misaligned_addr_out  (mis_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted request must match the next expected address.
  always @(negedge clk) begin
    if (i_req === 1'b1 && i_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected", i_addr, 32'hDEAD_BEEF);
      else                   chk("sb_addr", i_addr, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; i_ready = 1'b1;
    trap_taken = 1'b0; trap_address = '0; trap_return = 1'b0; epc = '0;
    branch_taken = 1'b0; iaddr = '0;
    #2;
    chk("rst_req", {31'b0, i_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mis", {31'b0, mis_instr}, 32'd0);
    chk("rst_mis_addr", mis_addr, 32'h0);

    // Boot: 0, 4, 8 then hold at 0xC
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    #10 rst_n = 1'b1;
    repeat (4) tick();
    stall = 1'b1;
    chk("boot_hold_pc", pc, 32'hC);

    // Branch to 0x80 taken on the accept of 0xC
    exp_q.push_back(32'hC); exp_q.push_back(32'h80); exp_q.push_back(32'h84);
    stall = 1'b0; branch_taken = 1'b1; iaddr = 31'h40;
    tick();
    branch_taken = 1'b0;
    tick();
    tick();
    stall = 1'b1;
    chk("branch_seq_pc", pc, 32'h88);

    // Idle redirect via trap return; low epc bits masked off
    trap_return = 1'b1; epc = 32'h13;
    tick();
    trap_return = 1'b0;
    chk("epc_mask", pc, 32'h10);

    // Stalled fetch at 0x10 buffers a trap; a lower-priority branch must not overwrite it
    stall = 1'b0; i_ready = 1'b0;
    tick();
    trap_taken = 1'b1; trap_address = 32'h200;
    tick();
    trap_taken = 1'b0; branch_taken = 1'b1; iaddr = 31'h200;
    stall = 1'b1;
    chk("wait_addr_hold", i_addr, 32'h10);
    #4;
    chk("wait_req_under_stall", {31'b0, i_req}, 32'd1);
    tick();
    branch_taken = 1'b0;
    chk("wait_addr_hold2", i_addr, 32'h10);
    exp_q.push_back(32'h10); exp_q.push_back(32'h200);
    stall = 1'b0; i_ready = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    chk("pending_seq_pc", pc, 32'h204);

    // Misaligned branch: pulse, address held, sequential flow continues
    exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    stall = 1'b0; branch_taken = 1'b1; iaddr = 31'h21;
    tick();
    branch_taken = 1'b0;
    chk("mis_pulse", {31'b0, mis_instr}, 32'd1);
    chk("mis_addr", mis_addr, 32'h42);
    chk("mis_no_redirect", pc, 32'h208);
    tick();
    stall = 1'b1;
    chk("mis_pulse_end", {31'b0, mis_instr}, 32'd0);
    chk("mis_addr_held", mis_addr, 32'h42);

    // Priority: trap beats return and branch on an accept
    exp_q.push_back(32'h20C); exp_q.push_back(32'h300);
    stall = 1'b0;
    trap_taken = 1'b1; trap_address = 32'h300;
    trap_return = 1'b1; epc = 32'h500;
    branch_taken = 1'b1; iaddr = 31'h80;
    tick();
    trap_taken = 1'b0; trap_return = 1'b0; branch_taken = 1'b0;
    tick();
    stall = 1'b1;
    chk("prio_seq_pc", pc, 32'h304);

    // Priority while idle: return beats branch
    trap_return = 1'b1; epc = 32'h600; branch_taken = 1'b1; iaddr = 31'h10;
    tick();
    trap_return = 1'b0; branch_taken = 1'b0;
    chk("ret_over_branch", pc, 32'h600);

    // Wrap at the top of the address space
    trap_taken = 1'b1; trap_address = 32'hFFFF_FFFF;
    tick();
    trap_taken = 1'b0;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_link", pc_plus_step, 32'h0);
    exp_q.push_back(32'hFFFF_FFFC);
    stall = 1'b0;
    tick();
    i_ready = 1'b0;
    chk("wrap_to_zero", pc, 32'h0);

    // Reset in WAIT with a pending branch: request drops at once, pending cleared
    tick();
    branch_taken = 1'b1; iaddr = 31'h40;
    tick();
    branch_taken = 1'b0;
    chk("wait_before_rst", {31'b0, i_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, i_req}, 32'd0);
    chk("async_rst_pc", pc, 32'h0);
    i_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    stall = 1'b1;
    chk("post_rst_pc", pc, 32'h8);
    tick();
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
